// File: rtl/iir_filter_pkg.sv
// Shared types and width/bound helpers for the multi-channel first-order IIR filter.
package iir_filter_pkg;

   typedef enum logic {
      MODE_LEGACY = 1'b0,
      MODE_COEF   = 1'b1
   } mode_e;

   // Three products of WIDTH x COEF_W bits plus headroom for their sum.
   function automatic int acc_width(input int width, input int coef_w);
      return width + coef_w + 2;
   endfunction

   function automatic longint sat_hi(input int width);
      return (longint'(1) <<< (width - 1)) - longint'(1);
   endfunction

   function automatic longint sat_lo(input int width);
      return -(longint'(1) <<< (width - 1));
   endfunction

endpackage

// File: rtl/iir_filter_mc_if.sv
// Valid/ready stream carrying a channel tag and one sample.
interface iir_filter_mc_if #(
   parameter int WIDTH = 16,
   parameter int CH_W  = 2
);
   logic             valid;
   logic             ready;
   logic [CH_W-1:0]  ch;
   logic [WIDTH-1:0] data;

   modport master (output valid, ch, data, input ready);
   modport slave  (input valid, ch, data, output ready);
endinterface

// File: rtl/iir_filter_mac.sv
// Combinational filter datapath: wrapping legacy sum or saturating fixed-point MAC.
module iir_filter_mac
   import iir_filter_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int COEF_W = 16,
   parameter int FRAC   = 14
)(
   input  mode_e                    mode,
   input  logic signed [COEF_W-1:0] b0,
   input  logic signed [COEF_W-1:0] b1,
   input  logic signed [COEF_W-1:0] a1,
   input  logic signed [WIDTH-1:0]  x,
   input  logic signed [WIDTH-1:0]  x_prev,
   input  logic signed [WIDTH-1:0]  y_prev,
   output logic signed [WIDTH-1:0]  y,
   output logic                     sat
);
   localparam int ACC_W = acc_width(WIDTH, COEF_W);
   typedef logic signed [ACC_W-1:0] acc_t;

   localparam acc_t                    ACC_HI = acc_t'(sat_hi(WIDTH));
   localparam acc_t                    ACC_LO = acc_t'(sat_lo(WIDTH));
   localparam logic signed [WIDTH-1:0] Y_HI   = WIDTH'(sat_hi(WIDTH));
   localparam logic signed [WIDTH-1:0] Y_LO   = WIDTH'(sat_lo(WIDTH));

   acc_t                    acc;
   acc_t                    shr;
   logic signed [WIDTH-1:0] wrap;

   always_comb begin
      acc  = acc_t'(b0) * acc_t'(x) + acc_t'(b1) * acc_t'(x_prev) + acc_t'(a1) * acc_t'(y_prev);
      // Arithmetic shift floors toward minus infinity, matching the fixed-point scaling.
      shr  = acc >>> FRAC;
      wrap = x + x_prev + y_prev;
      y    = wrap;
      sat  = 1'b0;
      if (mode == MODE_COEF) begin
         if (shr > ACC_HI) begin
            y   = Y_HI;
            sat = 1'b1;
         end else if (shr < ACC_LO) begin
            y   = Y_LO;
            sat = 1'b1;
         end else begin
            y   = shr[WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/iir_filter_mc.sv
// Time-multiplexed first-order IIR filter: stage A holds the accepted sample,
// stage B is the output register; channel history is written on the A->B move.
module iir_filter_mc
   import iir_filter_pkg::*;
#(
   parameter int  WIDTH    = 16,
   parameter int  COEF_W   = 16,
   parameter int  FRAC     = 14,
   parameter int  CHANNELS = 4,
   localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
)(
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clear,
   input  logic                     mode,
   input  logic signed [COEF_W-1:0] coef_b0,
   input  logic signed [COEF_W-1:0] coef_b1,
   input  logic signed [COEF_W-1:0] coef_a1,
   iir_filter_mc_if.slave           in_s,
   iir_filter_mc_if.master          out_m,
   output logic [CHANNELS-1:0]      ovf,
   input  logic                     ovf_clr
);
   logic                            a_vld;
   logic [CH_W-1:0]                 a_ch;
   logic signed [WIDTH-1:0]         a_x;
   logic                            b_vld;
   logic [CH_W-1:0]                 b_ch;
   logic signed [WIDTH-1:0]         b_y;
   logic [CHANNELS-1:0][WIDTH-1:0]  x_hist;
   logic [CHANNELS-1:0][WIDTH-1:0]  y_hist;

   logic                            a_adv;
   logic                            a_ok;
   logic [CH_W-1:0]                 a_idx;
   logic signed [WIDTH-1:0]         y_new;
   logic                            sat;

   assign a_adv      = a_vld && (!b_vld || out_m.ready);
   assign a_ok       = {1'b0, a_ch} < (CH_W + 1)'(CHANNELS);
   // Out-of-range tags still need a legal read index; their result is dropped.
   assign a_idx      = a_ok ? a_ch : '0;
   assign in_s.ready = !a_vld || a_adv;

   assign out_m.valid = b_vld;
   assign out_m.ch    = b_ch;
   assign out_m.data  = b_y;

   iir_filter_mac #(
      .WIDTH  (WIDTH),
      .COEF_W (COEF_W),
      .FRAC   (FRAC)
   ) u_mac (
      .mode   (mode_e'(mode)),
      .b0     (coef_b0),
      .b1     (coef_b1),
      .a1     (coef_a1),
      .x      (a_x),
      .x_prev ($signed(x_hist[a_idx])),
      .y_prev ($signed(y_hist[a_idx])),
      .y      (y_new),
      .sat    (sat)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_vld  <= 1'b0;
         a_ch   <= '0;
         a_x    <= '0;
         b_vld  <= 1'b0;
         b_ch   <= '0;
         b_y    <= '0;
         ovf    <= '0;
         x_hist <= '0;
         y_hist <= '0;
      end else if (clear) begin
         a_vld  <= 1'b0;
         b_vld  <= 1'b0;
         ovf    <= '0;
         x_hist <= '0;
         y_hist <= '0;
      end else begin
         if (in_s.ready) begin
            a_vld <= in_s.valid;
            if (in_s.valid) begin
               a_ch <= in_s.ch;
               a_x  <= $signed(in_s.data);
            end
         end

         if (a_adv && a_ok) begin
            b_vld         <= 1'b1;
            b_ch          <= a_ch;
            b_y           <= y_new;
            x_hist[a_idx] <= a_x;
            y_hist[a_idx] <= y_new;
         end else if (out_m.ready) begin
            b_vld <= 1'b0;
         end

         // A fresh saturation outranks a clear landing on the same edge.
         for (int i = 0; i < CHANNELS; i++) begin
            if (a_adv && a_ok && sat && (a_idx == CH_W'(i)))
               ovf[i] <= 1'b1;
            else if (ovf_clr)
               ovf[i] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_iir_filter_mc.sv
// Randomized and directed check of iir_filter_mc against a per-channel arithmetic model.
module tb_iir_filter_mc;
   localparam int WIDTH    = 16;
   localparam int COEF_W   = 16;
   localparam int FRAC     = 14;
   localparam int CHANNELS = 4;
   localparam int CH_W     = 2;

   typedef struct {int ch; int data; bit sat;} exp_t;
   typedef struct {int ch; int data; int cyc;} obs_t;

   logic clk;
   logic reset_n;
   logic clear;
   logic mode;
   logic signed [COEF_W-1:0] coef_b0, coef_b1, coef_a1;
   logic [CHANNELS-1:0] ovf;
   logic ovf_clr;

   iir_filter_mc_if #(.WIDTH(WIDTH), .CH_W(CH_W)) in_if ();
   iir_filter_mc_if #(.WIDTH(WIDTH), .CH_W(CH_W)) out_if ();

   iir_filter_mc #(
      .WIDTH(WIDTH), .COEF_W(COEF_W), .FRAC(FRAC), .CHANNELS(CHANNELS)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear),
      .mode    (mode),
      .coef_b0 (coef_b0),
      .coef_b1 (coef_b1),
      .coef_a1 (coef_a1),
      .in_s    (in_if),
      .out_m   (out_if),
      .ovf     (ovf),
      .ovf_clr (ovf_clr)
   );

   int n_cmp = 0;
   int n_mis = 0;
   int cyc   = 0;
   int rdy_mode = 0;
   exp_t exp_q[$];
   obs_t got_q[$];
   int mx [CHANNELS];
   int my [CHANNELS];
   logic [CHANNELS-1:0] m_ovf;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   // Output side: 0 = always ready, 1 = stalled, 2 = random back-pressure.
   initial begin
      out_if.ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       out_if.ready = 1'b1;
            1:       out_if.ready = 1'b0;
            default: out_if.ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Reference model: y for each accepted sample from the per-channel history.
   function automatic exp_t model_y(input int ch, input int x);
      exp_t e;
      longint acc;
      logic signed [WIDTH-1:0] w;
      e.ch = ch;
      e.sat = 1'b0;
      if (mode == 1'b0) begin
         w = WIDTH'(x + mx[ch] + my[ch]);
         e.data = int'(w);
      end else begin
         acc = longint'(coef_b0) * x + longint'(coef_b1) * mx[ch] + longint'(coef_a1) * my[ch];
         acc = acc >>> FRAC;
         if (acc > 32767)       begin e.data = 32767;  e.sat = 1'b1; end
         else if (acc < -32768) begin e.data = -32768; e.sat = 1'b1; end
         else                   e.data = int'(acc);
      end
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (!reset_n || clear) begin
         exp_q.delete();
         m_ovf = '0;
         for (int c = 0; c < CHANNELS; c++) begin mx[c] = 0; my[c] = 0; end
      end else begin
         if (ovf_clr) m_ovf = '0;
         if (out_if.valid && out_if.ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("out_ch", out_if.ch, e.ch);
               check("out_data", $signed(out_if.data), e.data);
               if (e.sat) m_ovf[e.ch] = 1'b1;
               got_q.push_back('{ch: int'(out_if.ch), data: int'($signed(out_if.data)), cyc: cyc});
            end
         end
         if (in_if.valid && in_if.ready) begin
            e = model_y(int'(in_if.ch), int'($signed(in_if.data)));
            mx[e.ch] = int'($signed(in_if.data));
            my[e.ch] = e.data;
            exp_q.push_back(e);
         end
      end
   end

   task automatic send(input int ch, input int d);
      int n = 0;
      logic hs = 1'b0;
      in_if.valid = 1'b1;
      in_if.ch    = CH_W'(ch);
      in_if.data  = WIDTH'(d);
      do begin
         @(negedge clk); hs = in_if.ready;
         @(posedge clk); #1;
         n++;
      end while (!hs && n < 200);
      if (!hs) check("send_timeout", 1, 0);
      in_if.valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      rdy_mode = 0;
      while ((exp_q.size() != 0 || out_if.valid) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 300) check("drain_timeout", n, 0);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
   endtask

   task automatic pulse_ovf_clr();
      ovf_clr = 1'b1;
      @(posedge clk); #1;
      ovf_clr = 1'b0;
   endtask

   task automatic chk_got(input string name, input int idx, input int ch, input int d);
      if (idx >= got_q.size()) begin
         check({name, "_missing"}, got_q.size(), idx + 1);
      end else begin
         check({name, "_ch"}, got_q[idx].ch, ch);
         check({name, "_data"}, got_q[idx].data, d);
      end
   endtask

   initial begin
      int base;
      reset_n = 1'b0; clear = 1'b0; mode = 1'b0; ovf_clr = 1'b0;
      coef_b0 = '0; coef_b1 = '0; coef_a1 = '0;
      in_if.valid = 1'b0; in_if.ch = '0; in_if.data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_if.valid, 0);
      check("rst_out_data", out_if.data, 0);
      check("rst_out_ch", out_if.ch, 0);
      check("rst_ovf", ovf, 0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", in_if.ready, 1);

      // Legacy accumulation with latency and back-to-back throughput.
      base = got_q.size();
      send(0, 1);
      check("lat_e0_valid", out_if.valid, 0);
      send(0, 2);
      check("lat_e1_valid", out_if.valid, 1);
      check("lat_e1_data", $signed(out_if.data), 1);
      send(0, 3);
      drain();
      chk_got("leg0", base, 0, 1);
      chk_got("leg1", base + 1, 0, 4);
      chk_got("leg2", base + 2, 0, 9);
      if (got_q.size() >= base + 3) begin
         check("leg_spacing1", got_q[base + 1].cyc - got_q[base].cyc, 1);
         check("leg_spacing2", got_q[base + 2].cyc - got_q[base + 1].cyc, 1);
      end else check("leg_count", got_q.size() - base, 3);

      // Coefficient mode without saturation.
      pulse_clear();
      mode = 1'b1; coef_b0 = 16'sh4000; coef_b1 = '0; coef_a1 = 16'sh2000;
      base = got_q.size();
      repeat (3) send(1, 1000);
      drain();
      chk_got("coef0", base, 1, 1000);
      chk_got("coef1", base + 1, 1, 1500);
      chk_got("coef2", base + 2, 1, 1750);
      check("coef_ovf", ovf, 0);

      // Saturation and sticky flag.
      coef_a1 = 16'sh4000;
      base = got_q.size();
      send(2, 30000);
      send(2, 30000);
      drain();
      chk_got("sat0", base, 2, 30000);
      chk_got("sat1", base + 1, 2, 32767);
      check("sat_ovf", ovf, 4'b0100);
      repeat (3) @(posedge clk);
      #1;
      check("sat_ovf_sticky", ovf, 4'b0100);
      pulse_ovf_clr();
      check("ovf_clr", ovf, 0);
      check("ovf_clr_model", ovf, m_ovf);

      // Clear and a new saturation on the same edge: saturation wins.
      send(2, 30000);
      pulse_ovf_clr();
      drain();
      check("ovf_clr_vs_sat", ovf, 4'b0100);
      check("ovf_clr_vs_sat_model", ovf, m_ovf);

      // Interleaved channels keep separate histories.
      pulse_clear();
      check("clear_ovf", ovf, 0);
      mode = 1'b0;
      base = got_q.size();
      send(0, 1); send(3, 10); send(0, 1); send(3, 10);
      drain();
      chk_got("il0", base, 0, 1);
      chk_got("il1", base + 1, 3, 10);
      chk_got("il2", base + 2, 0, 3);
      chk_got("il3", base + 3, 3, 30);

      // Back-pressure: two samples buffer, then input stalls.
      pulse_clear();
      rdy_mode = 1;
      repeat (2) @(posedge clk);
      #1;
      base = got_q.size();
      send(0, 100);
      send(1, 200);
      check("bp_in_ready", in_if.ready, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("bp_in_ready_hold", in_if.ready, 0);
      end
      rdy_mode = 0;
      send(2, 300); send(3, 400); send(0, 5);
      drain();
      check("bp_count", got_q.size() - base, 5);
      chk_got("bp0", base, 0, 100);
      chk_got("bp1", base + 1, 1, 200);
      chk_got("bp2", base + 2, 2, 300);
      chk_got("bp3", base + 3, 3, 400);
      chk_got("bp4", base + 4, 0, 205);

      // Asynchronous reset mid-burst.
      rdy_mode = 1;
      repeat (2) @(posedge clk);
      #1;
      send(0, 7); send(1, 8);
      #2 reset_n = 1'b0;
      #1;
      check("arst_out_valid", out_if.valid, 0);
      check("arst_out_data", out_if.data, 0);
      check("arst_out_ch", out_if.ch, 0);
      check("arst_ovf", ovf, 0);
      rdy_mode = 0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("arst_quiet", out_if.valid, 0);
         check("arst_in_ready", in_if.ready, 1);
      end

      // Synchronous clear mid-stream, then a fresh ch0 sample.
      rdy_mode = 1;
      repeat (2) @(posedge clk);
      #1;
      send(0, 50); send(1, 60);
      pulse_clear();
      check("clr_out_valid", out_if.valid, 0);
      check("clr_in_ready", in_if.ready, 1);
      rdy_mode = 0;
      mode = 1'b0;
      base = got_q.size();
      send(0, 5);
      drain();
      check("clr_count", got_q.size() - base, 1);
      chk_got("clr0", base, 0, 5);

      // Randomized bursts with random back-pressure, modes and coefficients.
      for (int b = 0; b < 10; b++) begin
         int n;
         mode    = 1'($urandom_range(0, 1));
         coef_b0 = COEF_W'($urandom);
         coef_b1 = COEF_W'($urandom);
         coef_a1 = COEF_W'($urandom);
         rdy_mode = 2;
         n = $urandom_range(20, 40);
         for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send($urandom_range(0, CHANNELS - 1), int'($signed(WIDTH'($urandom))));
         end
         drain();
         check("rand_ovf", ovf, m_ovf);
         if ($urandom_range(0, 1) == 1) begin
            pulse_ovf_clr();
            check("rand_ovf_clr", ovf, m_ovf);
         end
         if ($urandom_range(0, 3) == 0) pulse_clear();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/iir_filter_mc.md
IIR_FILTER_MC -- requirements
Module: iir_filter_mc

Interface
REQ-001 Parameter WIDTH, default 16, sample width, signed two's complement.
REQ-002 Parameter COEF_W, default 16, coefficient width, signed fixed point.
REQ-003 Parameter FRAC, default 14, fractional bits of each coefficient.
REQ-004 Parameter CHANNELS, default 4, number of independent time-multiplexed channels, >=1.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 clear  in  1  synchronous clear of all channel history and the pipeline.
REQ-008 mode  in  1  0 = legacy (y = x + x_prev + y_prev, wrapping); 1 = coefficient (saturating).
REQ-009 coef_b0, coef_b1, coef_a1  in  COEF_W each  filter coefficients, used only in mode 1.
REQ-010 in_valid / in_ready  in / out  1 / 1  input handshake.
REQ-011 in_ch  in  clog2(CHANNELS), minimum 1  channel index of the input sample.
REQ-012 in_data  in  WIDTH  input sample x[n].
REQ-013 out_valid / out_ready  out / in  1 / 1  output handshake.
REQ-014 out_ch, out_data  out  clog2(CHANNELS), minimum 1 / WIDTH  channel index and output y[n].
REQ-015 ovf  out  CHANNELS  sticky per-channel saturation flags.
REQ-016 ovf_clr  in  1  synchronous clear of all ovf bits.

Function
REQ-017 Transfer occurs on a rising edge where valid&&ready; payload never changes or drops while valid&&!ready.
REQ-018 Two stages: stage A holds the accepted sample and channel; stage B is the output register.
REQ-019 A->B move: compute y from stage-A sample and x_prev[ch], y_prev[ch]; load B; update x_prev[ch]=x, y_prev[ch]=y in the same edge.
REQ-020 Mode, coef_* sampled at the A->B move.
REQ-021 Latency: sample accepted at edge E has out_valid=1 after edge E+1 if B is free.
REQ-022 Full throughput: back-to-back same-channel samples need no stall (history written at A->B move).
REQ-023 B holds while out_valid&&!out_ready; A advances when B empty or draining this cycle.
REQ-024 in_ready = !A_valid || A advances this cycle (combinational from out_ready permitted).
REQ-025 Mode 0: y = (x + x_prev + y_prev) mod 2^WIDTH; ovf unaffected.
REQ-026 Mode 1: acc = b0*x + b1*x_prev + a1*y_prev at full precision (WIDTH+COEF_W+2 bits); arithmetic shift right by FRAC (floor); saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-027 Mode 1 saturation sets ovf[ch] at the A->B move; bit stays until ovf_clr, clear or reset.
REQ-028 Channel histories are fully independent; order of outputs equals order of inputs.
REQ-029 in_ch >= CHANNELS: sample accepted, discarded at A->B move, no output, no state change.
REQ-030 clear: pipeline valids, all x_prev, y_prev and ovf -> 0 next edge; in_valid ignored that cycle; dominates simultaneous transfers.
REQ-031 ovf_clr and a new saturation on the same edge: saturating bit ends set.

Reset
REQ-032 reset_n low: immediately out_valid=0, out_data=0, out_ch=0, ovf=0, stage A invalid, all histories 0; in_ready=1 after release.
REQ-033 Reset mid-transfer discards in-flight samples; no output after release until new input.

Structure
REQ-034 Package iir_filter_pkg holds the mode enum (MODE_LEGACY, MODE_COEF) and the accumulator-width and saturation-bound constant functions.
REQ-035 One sub-module iir_filter_mac: combinational multiply-accumulate, shift, saturate/wrap, overflow indication; histories in iir_filter_mc as CHANNELS-deep register arrays.

Verification (WIDTH=16, COEF_W=16, FRAC=14, CHANNELS=4)
REQ-036 Mode 0, ch0, inputs 1,2,3 back-to-back -> outputs 1,4,9, one per cycle, first 2 cycles after first accept.
REQ-037 Mode 1, b0=0x4000, b1=0, a1=0x2000, ch1 inputs 1000 x3 -> 1000,1500,1750; ovf=0.
REQ-038 Mode 1, b0=0x4000, b1=0, a1=0x4000, ch2 inputs 30000,30000 -> 30000,32767; ovf[2]=1 until ovf_clr.
REQ-039 Mode 0 interleaved ch0:1, ch3:10, ch0:1, ch3:10 -> 1,10,3,30 with matching out_ch.
REQ-040 out_ready low 3 cycles during a 5-sample burst -> in_ready low after 2 buffered; all 5 outputs in order, none lost or duplicated.
REQ-041 reset_n low mid-burst, then clear mid-stream -> out_valid=0 at once; next ch0 input 5 in mode 0 yields 5.
